// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: sweep FSM encodings
// and helpers that derive array geometry from the module parameters.
package regfile_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SWEEP = 1'b1;

    function automatic int depth_of(input int word_line);
        return 1 << word_line;
    endfunction

    function automatic int nbyte_of(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// Soft-clear sequencer: on a clr request from idle, walks every entry once,
// issuing one zeroing write per cycle.
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int unsigned WORD_LINE = 3
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 clr,
    output logic                 busy,
    output logic                 clr_we,
    output logic [WORD_LINE-1:0] clr_addr
);

    logic [0:0]           state_q, state_d;
    logic [WORD_LINE-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clr) begin
                    state_d = ST_SWEEP;
                    cnt_d   = '0;
                end
            end
            ST_SWEEP: begin
                cnt_d = cnt_q + 1'b1;
                // all-ones count is the last entry; the counter wraps back to zero
                if (cnt_q == '1) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy     = (state_q == ST_SWEEP);
    assign clr_we   = busy;
    assign clr_addr = cnt_q;

endmodule

// File: rtl/regfile_mp_clr.sv
// Multi-read-port register file with byte enables, optional write bypass,
// optional hardwired-zero entry 0 and a sequenced soft-clear.
module regfile_mp_clr
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned WORD_LINE = 3,
    parameter int unsigned NRD       = 2,
    parameter int unsigned ZERO_REG  = 0,
    parameter int unsigned BYPASS    = 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     we,
    input  logic [WORD_LINE-1:0]     wa,
    input  logic [WIDTH-1:0]         wd,
    input  logic [WIDTH/8-1:0]       wbe,
    input  logic [NRD*WORD_LINE-1:0] ra,
    output logic [NRD*WIDTH-1:0]     rd,
    input  logic                     clr,
    output logic                     busy,
    output logic                     wdrop
);

    localparam int DEPTH = depth_of(WORD_LINE);
    localparam int NBYTE = nbyte_of(WIDTH);

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic                 clr_we;
    logic [WORD_LINE-1:0] clr_addr;
    logic                 wr_en;
    logic [WIDTH-1:0]     wr_merge;
    logic                 wdrop_q;

    regfile_clr_seq #(
        .WORD_LINE (WORD_LINE)
    ) u_clr_seq (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (clr),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign wr_en = we && !busy && !((ZERO_REG != 0) && (wa == '0));

    // Byte-merged write word; shared by the array update and the bypass path.
    always_comb begin
        wr_merge = mem_q[wa];
        for (int b = 0; b < NBYTE; b++) begin
            if (wbe[b]) begin
                wr_merge[8*b +: 8] = wd[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end else if (wr_en) begin
            mem_q[wa] <= wr_merge;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wdrop_q <= 1'b0;
        end else begin
            wdrop_q <= we && busy;
        end
    end

    assign wdrop = wdrop_q;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [WORD_LINE-1:0] addr;
        assign addr = ra[k*WORD_LINE +: WORD_LINE];
        assign rd[k*WIDTH +: WIDTH] =
            ((ZERO_REG != 0) && (addr == '0))       ? '0       :
            ((BYPASS != 0) && wr_en && (wa == addr)) ? wr_merge :
                                                       mem_q[addr];
    end

endmodule
